// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe.sv
// Pipelined XNOR comparator bank with valid/ready flow control,
// word-equality flag and a saturating mismatch counter.
module gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  output logic [WIDTH-1:0] ZN,
  output logic             EQ,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] MISS_CNT,
  output logic             SAT
);

  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] zn_q;
  logic             eq_q;
  logic             v_out;
  logic             rdy1;
  logic             out_xfer;
  logic [CNT_W-1:0] cnt_q;
  logic             sat;
  logic             unused_pwr;

  assign unused_pwr = VDD ^ VSS;
  assign x_in       = A1 ~^ A2;

  generate
    if (STAGES == 1) begin : g_s1
      logic v1;

      assign rdy1  = !v1 | OUT_RDY;
      assign v_out = v1;

      // data loads only with a valid word so idle X inputs never land
      always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
          v1   <= 1'b0;
          zn_q <= '0;
          eq_q <= 1'b0;
        end else if (rdy1) begin
          v1 <= IN_VLD;
          if (IN_VLD) begin
            zn_q <= x_in;
            eq_q <= &x_in;
          end
        end
      end
    end else if (STAGES == 2) begin : g_s2
      logic             v1;
      logic             v2;
      logic             rdy2;
      logic [WIDTH-1:0] x1;

      assign rdy2  = !v2 | OUT_RDY;
      assign rdy1  = !v1 | rdy2;
      assign v_out = v2;

      always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
          v1 <= 1'b0;
          x1 <= '0;
        end else if (rdy1) begin
          v1 <= IN_VLD;
          if (IN_VLD) begin
            x1 <= x_in;
          end
        end
      end

      always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
          v2   <= 1'b0;
          zn_q <= '0;
          eq_q <= 1'b0;
        end else if (rdy2) begin
          v2 <= v1;
          if (v1) begin
            zn_q <= x1;
            eq_q <= &x1;
          end
        end
      end
    end else begin : g_bad
      $error("STAGES must be 1 or 2");
    end
  endgenerate

  assign out_xfer = v_out & OUT_RDY;
  assign sat      = &cnt_q;

  // clear takes priority over a coinciding mismatch
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else if (CNT_CLR) begin
      cnt_q <= '0;
    end else if (out_xfer && !eq_q && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign IN_RDY   = rdy1;
  assign ZN       = zn_q;
  assign EQ       = eq_q;
  assign OUT_VLD  = v_out;
  assign MISS_CNT = cnt_q;
  assign SAT      = sat;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe.sv
// Directed bench: main 8b/2-stage, 2-bit counter variant,
// and a 1-bit single-stage variant.
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe;

  typedef struct {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] zn;
    logic       eq;
  } vec8_t;

  typedef struct {
    logic a1;
    logic a2;
    logic zn;
    logic eq;
  } vec1_t;

  logic clk = 1'b0;
  logic rn;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  always #5 clk = ~clk;

  // main: WIDTH=8 STAGES=2 CNT_W=8
  logic [7:0] m_a1, m_a2, m_zn, m_cnt;
  logic       m_in_vld, m_in_rdy, m_eq, m_out_vld, m_out_rdy;
  logic       m_clr, m_sat;

  // sat: WIDTH=8 STAGES=2 CNT_W=2
  logic [7:0] s_a1, s_a2, s_zn;
  logic [1:0] s_cnt;
  logic       s_in_vld, s_in_rdy, s_eq, s_out_vld, s_out_rdy;
  logic       s_clr, s_sat;

  // one: WIDTH=1 STAGES=1 CNT_W=8
  logic       o_a1, o_a2, o_zn;
  logic [7:0] o_cnt;
  logic       o_in_vld, o_in_rdy, o_eq, o_out_vld, o_out_rdy;
  logic       o_clr, o_sat;

  gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe #(
    .WIDTH(8), .STAGES(2), .CNT_W(8)
  ) u_main (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss),
    .A1(m_a1), .A2(m_a2),
    .IN_VLD(m_in_vld), .IN_RDY(m_in_rdy),
    .ZN(m_zn), .EQ(m_eq),
    .OUT_VLD(m_out_vld), .OUT_RDY(m_out_rdy),
    .CNT_CLR(m_clr), .MISS_CNT(m_cnt), .SAT(m_sat)
  );

  gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe #(
    .WIDTH(8), .STAGES(2), .CNT_W(2)
  ) u_sat (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss),
    .A1(s_a1), .A2(s_a2),
    .IN_VLD(s_in_vld), .IN_RDY(s_in_rdy),
    .ZN(s_zn), .EQ(s_eq),
    .OUT_VLD(s_out_vld), .OUT_RDY(s_out_rdy),
    .CNT_CLR(s_clr), .MISS_CNT(s_cnt), .SAT(s_sat)
  );

  gf180mcu_fd_sc_mcu7t5v0__xnor_match_pipe #(
    .WIDTH(1), .STAGES(1), .CNT_W(8)
  ) u_one (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss),
    .A1(o_a1), .A2(o_a2),
    .IN_VLD(o_in_vld), .IN_RDY(o_in_rdy),
    .ZN(o_zn), .EQ(o_eq),
    .OUT_VLD(o_out_vld), .OUT_RDY(o_out_rdy),
    .CNT_CLR(o_clr), .MISS_CNT(o_cnt), .SAT(o_sat)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  vec8_t tbl[7];
  vec8_t bp[6];
  vec1_t t1[4];
  int    exp_miss;
  int    sent;
  int    got;
  int    exp_c;

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 8'hFF, 1'b1};
    tbl[1] = '{8'hA5, 8'h5A, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 8'hFF, 1'b1};
    tbl[4] = '{8'hF0, 8'hF1, 8'hFE, 1'b0};
    tbl[5] = '{8'h3C, 8'h3C, 8'hFF, 1'b1};
    tbl[6] = '{8'h80, 8'h00, 8'h7F, 1'b0};

    bp[0] = '{8'h11, 8'h11, 8'hFF, 1'b1};
    bp[1] = '{8'h22, 8'h20, 8'hFD, 1'b0};
    bp[2] = '{8'h33, 8'h33, 8'hFF, 1'b1};
    bp[3] = '{8'h44, 8'h40, 8'hFB, 1'b0};
    bp[4] = '{8'h55, 8'h55, 8'hFF, 1'b1};
    bp[5] = '{8'h66, 8'hE6, 8'h7F, 1'b0};

    t1[0] = '{1'b0, 1'b0, 1'b1, 1'b1};
    t1[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    t1[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // reset with busy random inputs
    rn = 1'b0;
    m_clr = 0; s_clr = 0; o_clr = 0;
    for (int i = 0; i < 3; i++) begin
      m_a1 = 8'($urandom); m_a2 = 8'($urandom);
      s_a1 = 8'($urandom); s_a2 = 8'($urandom);
      o_a1 = 1'($urandom); o_a2 = 1'($urandom);
      m_in_vld = 1; s_in_vld = 1; o_in_vld = 1;
      m_out_rdy = 1'($urandom); s_out_rdy = 1'($urandom);
      o_out_rdy = 1'($urandom);
      @(negedge clk);
      chk("rst_m_vld", m_out_vld, 0);
      chk("rst_m_rdy", m_in_rdy, 1);
      chk("rst_m_cnt", m_cnt, 0);
      chk("rst_m_sat", m_sat, 0);
    end
    chk("rst_s_vld", s_out_vld, 0);
    chk("rst_s_rdy", s_in_rdy, 1);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_o_vld", o_out_vld, 0);
    chk("rst_o_rdy", o_in_rdy, 1);
    chk("rst_o_sat", o_sat, 0);
    m_in_vld = 0; s_in_vld = 0; o_in_vld = 0;
    m_out_rdy = 1; s_out_rdy = 1; o_out_rdy = 1;
    rn = 1'b1;

    // single words, exact 2-edge latency
    exp_miss = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m_a1 = tbl[i].a1; m_a2 = tbl[i].a2; m_in_vld = 1;
      @(negedge clk);
      m_in_vld = 0; m_a1 = 8'($urandom); m_a2 = 8'($urandom);
      chk("tbl_early", m_out_vld, 0);
      @(negedge clk);
      chk("tbl_vld", m_out_vld, 1);
      chk("tbl_zn", m_zn, tbl[i].zn);
      chk("tbl_eq", m_eq, tbl[i].eq);
      if (!tbl[i].eq) exp_miss++;
      @(negedge clk);
      chk("tbl_cnt", m_cnt, exp_miss);
      chk("tbl_done", m_out_vld, 0);
    end

    // clear, then back-to-back equal/mismatch pair
    @(negedge clk); m_clr = 1;
    @(negedge clk); m_clr = 0;
    chk("clr_cnt", m_cnt, 0);
    m_a1 = 8'hA5; m_a2 = 8'hA5; m_in_vld = 1;
    @(negedge clk);
    m_a1 = 8'hA5; m_a2 = 8'h5A;
    @(negedge clk);
    m_in_vld = 0;
    chk("pair_vld0", m_out_vld, 1);
    chk("pair_zn0", m_zn, 8'hFF);
    chk("pair_eq0", m_eq, 1);
    @(negedge clk);
    chk("pair_zn1", m_zn, 8'h00);
    chk("pair_eq1", m_eq, 0);
    @(negedge clk);
    chk("pair_cnt", m_cnt, 1);
    chk("pair_end", m_out_vld, 0);

    // backpressure stream
    @(negedge clk); m_clr = 1;
    @(negedge clk); m_clr = 0;
    sent = 0; got = 0; exp_miss = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (cyc > 0) @(negedge clk);
      m_out_rdy = !(cyc >= 3 && cyc <= 6);
      m_in_vld = (sent < 6);
      if (sent < 6) begin
        m_a1 = bp[sent].a1; m_a2 = bp[sent].a2;
      end
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        chk("bp_in_rdy", m_in_rdy, 0);
        chk("bp_stall_vld", m_out_vld, 1);
        chk("bp_stall_zn", m_zn, bp[got].zn);
      end
      if (m_in_vld && m_in_rdy) sent++;
      if (m_out_vld && m_out_rdy) begin
        chk("bp_zn", m_zn, bp[got].zn);
        chk("bp_eq", m_eq, bp[got].eq);
        if (!bp[got].eq) exp_miss++;
        got++;
      end
    end
    chk("bp_got", got, 6);
    chk("bp_sent", sent, 6);
    @(negedge clk);
    m_in_vld = 0; m_out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_dup", m_out_vld, 0);
    end
    chk("bp_cnt", m_cnt, exp_miss);

    // saturation with 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      s_a1 = 8'(k); s_a2 = ~8'(k); s_in_vld = 1;
      @(negedge clk);
      s_in_vld = 0;
      for (int t = 0; t < 8 && !s_out_vld; t++) @(negedge clk);
      chk("sat_vld", s_out_vld, 1);
      chk("sat_eq", s_eq, 0);
      @(negedge clk);
      exp_c = (k < 3) ? k : 3;
      chk("sat_cnt", s_cnt, exp_c);
      chk("sat_flag", s_sat, (k >= 3) ? 1 : 0);
    end
    @(negedge clk);
    s_a1 = 8'h0F; s_a2 = 8'h00; s_in_vld = 1;
    @(negedge clk);
    s_in_vld = 0;
    for (int t = 0; t < 8 && !s_out_vld; t++) @(negedge clk);
    chk("satclr_vld", s_out_vld, 1);
    s_clr = 1;
    @(negedge clk);
    s_clr = 0;
    chk("satclr_cnt", s_cnt, 0);
    chk("satclr_sat", s_sat, 0);

    // 1-bit single stage, exhaustive stream
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("one_vld", o_out_vld, 1);
        chk("one_zn", o_zn, t1[i-1].zn);
        chk("one_eq", o_eq, t1[i-1].eq);
      end
      o_in_vld = (i < 4);
      if (i < 4) begin
        o_a1 = t1[i].a1; o_a2 = t1[i].a2;
      end
    end
    @(negedge clk);
    chk("one_idle", o_out_vld, 0);
    chk("one_cnt", o_cnt, 2);

    // reset with two words in flight
    @(negedge clk);
    m_out_rdy = 0;
    m_a1 = 8'h01; m_a2 = 8'h02; m_in_vld = 1;
    @(negedge clk);
    m_a1 = 8'h03; m_a2 = 8'h04;
    @(negedge clk);
    m_in_vld = 0;
    m_a1 = 'x; m_a2 = 'x;
    chk("mid_pre_vld", m_out_vld, 1);
    chk("mid_pre_rdy", m_in_rdy, 0);
    #2 rn = 1'b0;
    #1;
    chk("mid_vld", m_out_vld, 0);
    chk("mid_rdy", m_in_rdy, 1);
    chk("mid_cnt", m_cnt, 0);
    @(negedge clk);
    rn = 1'b1; m_out_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_stale", m_out_vld, 0);
      chk("mid_cnt_after", m_cnt, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
